// File: rtl/ex_pkg.sv
// Shared definitions for the execute-result stage: state encoding, register-index width, XLEN default.
package ex_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_W    = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/ex_result_entry.sv
// One slot of the execute-result skid buffer: {valid, result, rd, reg_wr}.
// Clear wins over load and zeroes the whole slot, so an empty slot always reads as 0.
module ex_result_entry
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [XLEN-1:0]  d_result,
    input  logic [REG_W-1:0] d_rd,
    input  logic             d_reg_wr,
    output logic             valid,
    output logic [XLEN-1:0]  result,
    output logic [REG_W-1:0] rd,
    output logic             reg_wr
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid  <= 1'b0;
            result <= '0;
            rd     <= '0;
            reg_wr <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            result <= d_result;
            rd     <= d_rd;
            reg_wr <= d_reg_wr;
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// Two-entry skid buffer between execute and writeback; In_Ready is registered (no path from Out_Ready).
// Optional forwarding outputs Fwd_* are built when EX_RESULT_FWD_EN is defined.
module ex_result_stage
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [XLEN-1:0]  In_Result,
    input  logic [REG_W-1:0] In_Rd,
    input  logic             In_Reg_Wr,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [XLEN-1:0]  Out_Result,
    output logic [REG_W-1:0] Out_Rd,
    output logic             Out_Reg_Wr
`ifdef EX_RESULT_FWD_EN
    ,
    output logic             Fwd_Valid,
    output logic [REG_W-1:0] Fwd_Rd,
    output logic [XLEN-1:0]  Fwd_Data
`endif
);

    stage_state_e     state_q;
    logic             in_ready_q;
    logic             accept, pop, in_reg_wr_eff;
    logic             head_load, head_clear, tail_load, tail_clear, head_from_tail;
    logic             head_valid, tail_valid;
    logic [XLEN-1:0]  head_result, tail_result, head_d_result;
    logic [REG_W-1:0] head_rd, tail_rd, head_d_rd;
    logic             head_reg_wr, tail_reg_wr, head_d_reg_wr;

    assign accept        = In_Valid & in_ready_q;
    assign pop           = head_valid & Out_Ready;
    // x0 is hardwired zero, so a write to it is dropped at capture time.
    assign in_reg_wr_eff = In_Reg_Wr & (In_Rd != '0);

    always_comb begin
        head_load      = 1'b0;
        head_clear     = Flush;
        tail_load      = 1'b0;
        tail_clear     = Flush;
        head_from_tail = 1'b0;
        if (!Flush) begin
            case (state_q)
                ST_EMPTY: head_load = accept;
                ST_ONE: begin
                    if (pop) begin
                        head_load  = accept;
                        head_clear = ~accept;
                    end else begin
                        tail_load  = accept;
                    end
                end
                ST_FULL: begin
                    head_load      = pop & tail_valid;
                    head_from_tail = 1'b1;
                    tail_clear     = pop;
                end
                default: ;
            endcase
        end
    end

    assign head_d_result = head_from_tail ? tail_result : In_Result;
    assign head_d_rd     = head_from_tail ? tail_rd     : In_Rd;
    assign head_d_reg_wr = head_from_tail ? tail_reg_wr : in_reg_wr_eff;

    always_ff @(posedge CLK) begin
        if (RST || Flush) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_q <= ST_ONE;
                ST_ONE: begin
                    if (accept && !pop) begin
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop && !accept) begin
                        state_q    <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    ex_result_entry #(.XLEN(XLEN)) u_head (
        .clk      (CLK),
        .rst      (RST),
        .load     (head_load),
        .clear    (head_clear),
        .d_result (head_d_result),
        .d_rd     (head_d_rd),
        .d_reg_wr (head_d_reg_wr),
        .valid    (head_valid),
        .result   (head_result),
        .rd       (head_rd),
        .reg_wr   (head_reg_wr)
    );

    ex_result_entry #(.XLEN(XLEN)) u_tail (
        .clk      (CLK),
        .rst      (RST),
        .load     (tail_load),
        .clear    (tail_clear),
        .d_result (In_Result),
        .d_rd     (In_Rd),
        .d_reg_wr (in_reg_wr_eff),
        .valid    (tail_valid),
        .result   (tail_result),
        .rd       (tail_rd),
        .reg_wr   (tail_reg_wr)
    );

    assign In_Ready   = in_ready_q;
    assign Out_Valid  = head_valid;
    assign Out_Result = head_result;
    assign Out_Rd     = head_rd;
    assign Out_Reg_Wr = head_reg_wr;

`ifdef EX_RESULT_FWD_EN
    // The tail is always younger than the head, so it is checked first.
    always_comb begin
        Fwd_Valid = 1'b0;
        Fwd_Rd    = '0;
        Fwd_Data  = '0;
        if (tail_valid && tail_reg_wr) begin
            Fwd_Valid = 1'b1;
            Fwd_Rd    = tail_rd;
            Fwd_Data  = tail_result;
        end else if (head_valid && head_reg_wr) begin
            Fwd_Valid = 1'b1;
            Fwd_Rd    = head_rd;
            Fwd_Data  = head_result;
        end
    end
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage; forwarding checks are built when EX_RESULT_FWD_EN is defined.
module tb_ex_result_stage;

    localparam int XLEN = 32;
    localparam int PW   = XLEN + 6;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            In_Valid = 1'b0;
    logic            In_Ready;
    logic [XLEN-1:0] In_Result = '0;
    logic [4:0]      In_Rd = '0;
    logic            In_Reg_Wr = 1'b0;
    logic            Flush = 1'b0;
    logic            Out_Valid;
    logic            Out_Ready = 1'b0;
    logic [XLEN-1:0] Out_Result;
    logic [4:0]      Out_Rd;
    logic            Out_Reg_Wr;
`ifdef EX_RESULT_FWD_EN
    logic            Fwd_Valid;
    logic [4:0]      Fwd_Rd;
    logic [XLEN-1:0] Fwd_Data;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [PW-1:0] q[$];
    logic [PW-1:0] exp_pk;
    logic [PW-1:0] out_pk;

    assign out_pk = {Out_Result, Out_Rd, Out_Reg_Wr};

    always #5 CLK = ~CLK;

    ex_result_stage #(.XLEN(XLEN)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .In_Result  (In_Result),
        .In_Rd      (In_Rd),
        .In_Reg_Wr  (In_Reg_Wr),
        .Flush      (Flush),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Out_Result (Out_Result),
        .Out_Rd     (Out_Rd),
        .Out_Reg_Wr (Out_Reg_Wr)
`ifdef EX_RESULT_FWD_EN
        ,
        .Fwd_Valid  (Fwd_Valid),
        .Fwd_Rd     (Fwd_Rd),
        .Fwd_Data   (Fwd_Data)
`endif
    );

    // Bookkeeping for the edge about to happen, then advance to just after it.
    task automatic step();
        if (RST || Flush) begin
            q.delete();
        end else begin
            if (Out_Valid && Out_Ready && q.size() > 0) void'(q.pop_front());
            if (In_Valid && In_Ready)
                q.push_back({In_Result, In_Rd, In_Reg_Wr && (In_Rd != 5'd0)});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] res, input logic [4:0] rd, input logic wr);
        In_Valid  = v;
        In_Result = res;
        In_Rd     = rd;
        In_Reg_Wr = wr;
    endtask

    function automatic logic [PW-1:0] head_exp();
        if (q.size() > 0) return q[0];
        return 'x;
    endfunction

`ifdef EX_RESULT_FWD_EN
    function automatic logic [PW-1:0] fwd_exp();
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i][0]) return q[i];
        return '0;
    endfunction
`endif

    task automatic test_reset();
        drive(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1);
        step();
        RST = 1'b1;
        step();
        step();
        drive(1'b0, '0, '0, 1'b0);
        n_cmp++; if (Out_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", Out_Valid); end
        n_cmp++; if (In_Ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", In_Ready); end
        n_cmp++; if (out_pk !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_pk); end
`ifdef EX_RESULT_FWD_EN
        n_cmp++; if (Fwd_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_fwd_valid: got %b want 0", Fwd_Valid); end
`endif
        RST = 1'b0;
        step();
    endtask

    task automatic test_pass_through();
        Out_Ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 5'd5, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        n_cmp++; if (Out_Valid !== 1'b1) begin n_bad++; $display("FAIL pass_valid: got %b want 1", Out_Valid); end
        exp_pk = head_exp();
        n_cmp++; if (out_pk !== exp_pk) begin n_bad++; $display("FAIL pass_data: got %h want %h", out_pk, exp_pk); end
        n_cmp++; if (out_pk !== {32'h8000_0000, 5'd5, 1'b1}) begin n_bad++; $display("FAIL pass_literal: got %h want 80000000/5/1", out_pk); end
        step();
        n_cmp++; if (Out_Valid !== 1'b0 || out_pk !== '0) begin n_bad++; $display("FAIL pass_empty_zero: got v=%b %h want v=0 0", Out_Valid, out_pk); end
    endtask

    task automatic test_backpressure();
        Out_Ready = 1'b0;
        drive(1'b1, 32'h11, 5'd1, 1'b1);
        step();
        n_cmp++; if (In_Ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one: got %b want 1", In_Ready); end
        drive(1'b1, 32'h22, 5'd2, 1'b1);
        step();
        n_cmp++; if (In_Ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", In_Ready); end
        drive(1'b1, 32'h33, 5'd3, 1'b1);
        step();
        step();
        drive(1'b0, '0, '0, 1'b0);
        n_cmp++; if (In_Ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_hold: got %b want 0", In_Ready); end
        n_cmp++; if (Out_Result !== 32'h11) begin n_bad++; $display("FAIL bp_head_hold: got %h want 11", Out_Result); end
        Out_Ready = 1'b1;
        exp_pk = head_exp();
        n_cmp++; if (out_pk !== exp_pk || Out_Result !== 32'h11) begin n_bad++; $display("FAIL bp_first: got %h want %h", out_pk, exp_pk); end
        step();
        exp_pk = head_exp();
        n_cmp++; if (out_pk !== exp_pk || Out_Result !== 32'h22) begin n_bad++; $display("FAIL bp_second: got %h want %h", out_pk, exp_pk); end
        step();
        n_cmp++; if (Out_Valid !== 1'b0 || q.size() != 0) begin n_bad++; $display("FAIL bp_drained: got v=%b want 0 (0x33 dropped)", Out_Valid); end
    endtask

    task automatic test_push_pop_one();
        Out_Ready = 1'b0;
        drive(1'b1, 32'hAA, 5'd3, 1'b1);
        step();
        Out_Ready = 1'b1;
        drive(1'b1, 32'hBB, 5'd4, 1'b0);
        n_cmp++; if (Out_Result !== 32'hAA) begin n_bad++; $display("FAIL pp_head_aa: got %h want aa", Out_Result); end
        step();
        drive(1'b0, '0, '0, 1'b0);
        exp_pk = head_exp();
        n_cmp++; if (out_pk !== exp_pk || Out_Result !== 32'hBB) begin n_bad++; $display("FAIL pp_head_bb: got %h want %h", out_pk, exp_pk); end
        n_cmp++; if (In_Ready !== 1'b1 || q.size() != 1) begin n_bad++; $display("FAIL pp_state_one: got ready=%b want 1", In_Ready); end
        step();
        n_cmp++; if (Out_Valid !== 1'b0) begin n_bad++; $display("FAIL pp_drain: got %b want 0", Out_Valid); end
    endtask

    task automatic test_x0_write();
        Out_Ready = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        exp_pk = head_exp();
        n_cmp++; if (Out_Reg_Wr !== 1'b0) begin n_bad++; $display("FAIL x0_reg_wr: got %b want 0", Out_Reg_Wr); end
        n_cmp++; if (out_pk !== exp_pk) begin n_bad++; $display("FAIL x0_data: got %h want %h", out_pk, exp_pk); end
`ifdef EX_RESULT_FWD_EN
        n_cmp++; if (Fwd_Valid !== 1'b0) begin n_bad++; $display("FAIL x0_fwd: got %b want 0", Fwd_Valid); end
`endif
        Out_Ready = 1'b1;
        step();
    endtask

    task automatic test_flush();
        Out_Ready = 1'b0;
        drive(1'b1, 32'h44, 5'd6, 1'b1);
        step();
        drive(1'b1, 32'h45, 5'd7, 1'b1);
        step();
        n_cmp++; if (In_Ready !== 1'b0) begin n_bad++; $display("FAIL flush_full_setup: got %b want 0", In_Ready); end
        drive(1'b1, 32'h55, 5'd8, 1'b1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        n_cmp++; if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin n_bad++; $display("FAIL flush_full: got v=%b r=%b want v=0 r=1", Out_Valid, In_Ready); end
        n_cmp++; if (out_pk !== '0) begin n_bad++; $display("FAIL flush_full_zero: got %h want 0", out_pk); end
`ifdef EX_RESULT_FWD_EN
        n_cmp++; if (Fwd_Valid !== 1'b0) begin n_bad++; $display("FAIL flush_fwd: got %b want 0", Fwd_Valid); end
`endif
        drive(1'b1, 32'h61, 5'd9, 1'b1);
        step();
        drive(1'b1, 32'h66, 5'd10, 1'b1);
        Out_Ready = 1'b1;
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        n_cmp++; if (Out_Valid !== 1'b0) begin n_bad++; $display("FAIL flush_one_accept: got %b want 0", Out_Valid); end
        step();
        n_cmp++; if (Out_Valid !== 1'b0) begin n_bad++; $display("FAIL flush_discard: got %b want 0", Out_Valid); end
    endtask

    task automatic test_reset_drops_entry();
        Out_Ready = 1'b0;
        drive(1'b1, 32'h77, 5'd11, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        n_cmp++; if (Out_Valid !== 1'b0 || out_pk !== '0) begin n_bad++; $display("FAIL rst_drop: got v=%b %h want 0", Out_Valid, out_pk); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            Out_Ready = ($urandom_range(0, 3) != 0);
            Flush = ($urandom_range(0, 31) == 0);
            n_cmp++; if (Out_Valid !== (q.size() > 0)) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, Out_Valid, q.size() > 0); end
            n_cmp++; if (In_Ready !== (q.size() < 2)) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, In_Ready, q.size() < 2); end
            exp_pk = (q.size() > 0) ? q[0] : '0;
            n_cmp++; if (out_pk !== exp_pk) begin n_bad++; $display("FAIL b2b_head[%0d]: got %h want %h", i, out_pk, exp_pk); end
`ifdef EX_RESULT_FWD_EN
            exp_pk = fwd_exp();
            n_cmp++; if ({Fwd_Data, Fwd_Rd, Fwd_Valid} !== exp_pk) begin n_bad++; $display("FAIL b2b_fwd[%0d]: got %h want %h", i, {Fwd_Data, Fwd_Rd, Fwd_Valid}, exp_pk); end
`endif
            step();
        end
        Flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        Out_Ready = 1'b1;
        step();
        step();
        n_cmp++; if (Out_Valid !== 1'b0 || q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got v=%b q=%0d want 0", Out_Valid, q.size()); end
    endtask

    initial begin
        #1;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_push_pop_one();
        test_x0_write();
        test_flush();
        test_reset_drops_entry();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
